dmem_bytewise: RTL
==================

DMEM_BYTEWISE -- requirements
Module: dmem_bytewise

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words; power of two, 16..4096.
REQ-002 Parameter AW, default $clog2(DEPTH): word-index width, derived and not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  access request, qualified by ready.
REQ-006 we  input  1  1 = store, 0 = load.
REQ-007 funct3  input  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr  input  32  byte address; index = addr[AW+1:2]; upper bits ignored, so the index wraps.
REQ-009 wdata  input  32  store data; B/H take the low 8/16 bits.
REQ-010 ready  output  1  block can accept a request this cycle.
REQ-011 rvalid  output  1  one-cycle response pulse for every accepted request.
REQ-012 rdata  output  32  load result, valid while rvalid=1; 0 otherwise.
REQ-013 err  output  1  error flag, valid while rvalid=1; 0 otherwise.

Function
REQ-014 States: CLEAR and IDLE. CLEAR is entered on reset. IDLE follows CLEAR.
REQ-015 CLEAR writes zero to word[cnt] each cycle, cnt running 0..DEPTH-1. Move to IDLE after cnt=DEPTH-1, which takes DEPTH cycles. ready=0 throughout.
REQ-016 IDLE: ready=1 every cycle. A request is accepted when req&&ready.
REQ-017 A request seen while ready=0 is ignored: no write, no response. The requester must hold req.
REQ-018 Load: rdata/rvalid are registered, so latency is exactly 1 cycle after acceptance.
REQ-019 Load lane = addr[1:0] for B/BU and addr[1] for H/HU.
REQ-020 B and H sign-extend to 32 bits. BU and HU zero-extend. W returns the word unchanged.
REQ-021 Store: byte enables follow from funct3/addr[1:0]. Only the enabled bytes update, on the accept edge. rvalid pulses the next cycle with rdata=0.
REQ-022 Back-to-back accepted requests are allowed every cycle, with no bubble.
REQ-023 Load immediately after a store to the same word returns the updated data.
REQ-024 Load and store in the same cycle is impossible: the single port accepts one request per cycle.
REQ-025 funct3 of 011, 110 or 111 (or BU/HU with we=1): no write, rvalid=1, err=1, rdata=0.
REQ-026 Memory contents have no reset other than the CLEAR sweep.

Reset
REQ-027 While rst_n=0: state=CLEAR, cnt=0, ready=0, rvalid=0, rdata=0, err=0.
REQ-028 Reset asserted mid-CLEAR or mid-operation restarts the full CLEAR sweep from cnt=0.
REQ-029 Reset asserted mid-operation drops any pending response.
REQ-030 Release of rst_n is assumed synchronous to clk by the system reset synchroniser.

Configuration
REQ-031 Macro DMEM_MISALIGN_TRAP_EN.
REQ-032 Defined: a misaligned access (H with addr[0]=1, or W with addr[1:0]!=0) raises err=1 with rvalid. It performs no write and returns rdata=0.
REQ-033 Undefined: misaligned low address bits are forced to zero and the access completes normally with err=0. No trap logic is synthesised.

Verification
REQ-034 Reset, then count cycles: ready rises exactly DEPTH cycles after rst_n release. A load of index DEPTH-1 returns 0x00000000.
REQ-035 Store then load:
- SW 0x8000_00FF to 0x10, then LB at 0x10 -> 0xFFFFFFFF.
- LBU at 0x10 -> 0x000000FF.
- LH at 0x12 -> 0xFFFF8000.
REQ-036 Byte-enable check:
- SW 0x11223344 to 0x20, then SB 0xAA to 0x21, then SH 0xBEEF to 0x22.
- LW at 0x20 -> 0xBEEFAA44.
REQ-037 Wrap-around: with DEPTH=256, SW 0xCAFEF00D to 0x400, then LW at 0x000 -> 0xCAFEF00D.
REQ-038 Misaligned access: LW at 0x21.
- With macro defined -> err=1, rdata=0, memory unchanged.
- With macro undefined -> data of 0x20, err=0.
REQ-039 Reset mid-CLEAR and mid-stream:
- Assert rst_n=0 at cnt=100 -> ready stays 0 for DEPTH cycles after release.
- Assert reset with an outstanding load -> no rvalid pulse.

Source files
------------

// File: rtl/dmem_bytewise.sv
// dmem_bytewise: single-port 32-bit data memory with RV32I byte/half/word
// loads and stores, a power-on CLEAR sweep and a one-cycle registered response.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN.
//   defined   -> misaligned H/HU/W accesses return err=1 with no write.
//   undefined -> misaligned low address bits are ignored (access is aligned down).
module dmem_bytewise #(
   parameter  int DEPTH = 256,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        rvalid,
   output logic [31:0] rdata,
   output logic        err
);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic [31:0]     mem_q [DEPTH];

   logic            rvalid_q, rvalid_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            err_q, err_d;

   logic            ready_s;
   logic            acc_s;
   logic            illegal_s;
   logic            bad_s;
   logic [AW-1:0]   idx_s;
   logic [31:0]     word_s;
   logic [31:0]     shift_s;
   logic [31:0]     ld_data_s;
   logic [31:0]     st_data_s;
   logic [3:0]      be_s;

   logic            mem_we_s;
   logic [AW-1:0]   mem_idx_s;
   logic [31:0]     mem_wdata_s;
   logic [3:0]      mem_be_s;

   // Address bits above the word index are deliberately ignored (index wraps).
   logic            unused_s;
   assign unused_s = ^addr[31:AW+2];

   assign idx_s   = addr[AW+1:2];
   assign word_s  = mem_q[idx_s];
   assign ready_s = (state_q == ST_IDLE);
   assign acc_s   = req && ready_s;

   // State and sweep-counter registers; reset restarts the CLEAR sweep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_CLEAR;
         cnt_q   <= {AW{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: sweep every word once in CLEAR, then stay in IDLE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_CLEAR: begin
            cnt_d = cnt_q + {{(AW-1){1'b0}}, 1'b1};
            if (cnt_q == AW'(DEPTH - 1)) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_CLEAR;
            end
         end
         ST_IDLE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_CLEAR;
            cnt_d   = {AW{1'b0}};
         end
      endcase
   end

   // Size decode: byte enables, replicated store data and extended load data.
   always_comb begin
      be_s      = 4'b0000;
      st_data_s = 32'h0000_0000;
      shift_s   = 32'h0000_0000;
      ld_data_s = 32'h0000_0000;
      illegal_s = 1'b0;
      case (funct3)
         3'b000, 3'b100: begin
            be_s      = 4'b0001 << addr[1:0];
            st_data_s = {4{wdata[7:0]}};
            shift_s   = word_s >> {addr[1:0], 3'b000};
            ld_data_s = funct3[2] ? {24'h00_0000, shift_s[7:0]}
                                  : {{24{shift_s[7]}}, shift_s[7:0]};
            illegal_s = we && funct3[2];
         end
         3'b001, 3'b101: begin
            be_s      = addr[1] ? 4'b1100 : 4'b0011;
            st_data_s = {2{wdata[15:0]}};
            shift_s   = word_s >> {addr[1], 4'b0000};
            ld_data_s = funct3[2] ? {16'h0000, shift_s[15:0]}
                                  : {{16{shift_s[15]}}, shift_s[15:0]};
            illegal_s = we && funct3[2];
         end
         3'b010: begin
            be_s      = 4'b1111;
            st_data_s = wdata;
            ld_data_s = word_s;
         end
         default: begin
            illegal_s = 1'b1;
         end
      endcase
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   logic misal_s;

   // Misalignment detection: halfwords need addr[0]=0, words need addr[1:0]=0.
   always_comb begin
      misal_s = 1'b0;
      case (funct3)
         3'b001, 3'b101: misal_s = addr[0];
         3'b010:         misal_s = |addr[1:0];
         default:        misal_s = 1'b0;
      endcase
   end

   assign bad_s = illegal_s | misal_s;
`else
   assign bad_s = illegal_s;
`endif

   // Memory write port: CLEAR sweep zeroes word[cnt], IDLE performs legal stores.
   always_comb begin
      mem_we_s    = 1'b0;
      mem_idx_s   = idx_s;
      mem_wdata_s = st_data_s;
      mem_be_s    = be_s;
      if (state_q == ST_CLEAR) begin
         mem_we_s    = 1'b1;
         mem_idx_s   = cnt_q;
         mem_wdata_s = 32'h0000_0000;
         mem_be_s    = 4'b1111;
      end else begin
         mem_we_s    = acc_s && we && !bad_s;
      end
   end

   // Storage array, byte-lane writes; contents are only initialised by CLEAR.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (mem_we_s && mem_be_s[b]) begin
            mem_q[mem_idx_s][8*b +: 8] <= mem_wdata_s[8*b +: 8];
         end
      end
   end

   // Response for the request accepted this cycle; rdata/err are zero otherwise.
   always_comb begin
      rvalid_d = acc_s;
      err_d    = acc_s && bad_s;
      if (acc_s && !we && !bad_s) begin
         rdata_d = ld_data_s;
      end else begin
         rdata_d = 32'h0000_0000;
      end
   end

   // Registered response outputs; reset drops any pending response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_q <= 1'b0;
         rdata_q  <= 32'h0000_0000;
         err_q    <= 1'b0;
      end else begin
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign ready  = ready_s;
   assign rvalid = rvalid_q;
   assign rdata  = rdata_q;
   assign err    = err_q;

endmodule
